of_ex_latch: RTL and testbench
==============================

Name: of_ex_latch

Overview:
- Operand-fetch to execute pipeline register for the SimpleRisc core; sits directly upstream of the execute-stage ALU and barrel shifter (ushifter).
- Latches a decoded instruction and its register operands, builds operand B from the immediate modifiers, and resolves MA/RW forwarding.
- Drives the shifter's m, n and is_lsl/is_lsr/is_asr inputs from registers with a valid/ready handshake, stall hold and branch flush.

Parameters:
XLEN, 32, datapath width (operands, PC, shifter m)
RIDX_W, 4, register index width (16 registers; r0 is not hardwired to zero)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
of_valid  in  1  OF stage presents an instruction
of_ready  out  1  latch accepts this cycle
of_inst  in  32  instruction: opcode[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14], imm[17:0]
of_pc  in  XLEN  PC of the instruction
of_op1  in  XLEN  register-file value of rs1
of_op2  in  XLEN  register-file value of rs2
flush  in  1  branch taken; kill the held and incoming instruction
ex_ready  in  1  EX can consume (low while a multicycle op is busy)
ma_wr_en, ma_rd, ma_val  in  1/RIDX_W/XLEN  pending writeback in MA stage
rw_wr_en, rw_rd, rw_val  in  1/RIDX_W/XLEN  pending writeback in RW stage
ex_valid  out  1  EX-stage contents valid
ex_pc  out  XLEN  latched PC
ex_opcode  out  5  latched opcode
ex_rd  out  RIDX_W  latched destination
ex_a  out  XLEN  operand A (forwarded rs1)
ex_b  out  XLEN  operand B (immediate or forwarded rs2)
sh_m  out  XLEN  shifter data input, equals ex_a
sh_n  out  5  shifter amount, equals ex_b[4:0]
sh_is_lsl, sh_is_lsr, sh_is_asr  out  1 each  one-hot shift select; all 0 for non-shift opcodes or when ex_valid=0

Behaviour:
- Reset (rst=1 at a clk edge): every output register becomes 0, including ex_valid and the sh_is_* bits. of_ready=1 in the first cycle after reset. rst asserted mid-transfer discards the instruction.
- of_ready = !ex_valid || ex_ready (combinational). Transfer occurs when of_valid && of_ready && !flush. On transfer, all ex_* and sh_* outputs update at the next edge, giving one-cycle latency. ex_valid is then 1.
- If ex_valid && ex_ready and no transfer occurs, ex_valid goes to 0 at the next edge. The data registers may keep stale values, but sh_is_* must clear.
- Hold: while ex_valid && !ex_ready, all outputs stay bit-stable for any number of cycles.
- Flush: ex_valid=0 and sh_is_*=0 at the next edge, regardless of of_valid/ex_ready. Flush has priority over transfer and over hold.
- Operand A is of_op1, replaced by a forwarded value when forwarding applies.
- Operand B when I=1, selected by modifier imm[17:16]:
  - 00: sign-extend imm[15:0].
  - 01: zero-extend imm[15:0].
  - 10: {imm[15:0], 16'h0}.
  - 11: treated as 00.
- Operand B when I=0: of_op2, replaced by a forwarded value when forwarding applies.
- Forwarding is evaluated in the transfer cycle, per source register s (rs1; rs2 only when I=0):
  - ma_wr_en && ma_rd==s → use ma_val.
  - Otherwise rw_wr_en && rw_rd==s → use rw_val.
  - Otherwise use the register-file value.
  - MA wins when MA and RW both match.
- Shift decode: opcode 01010 sets sh_is_lsl, 01011 sets sh_is_lsr, 01100 sets sh_is_asr; at most one bit is set. sh_n uses ex_b[4:0]; upper bits of ex_b are ignored by the shifter.
- Simultaneous of_valid and ex_ready while holding: the old instruction is consumed and the new one latched in the same edge (back-to-back throughput of 1 per cycle).

Optional Feature:
- Macro: OF_EX_FWD_EN.
- Defined: MA/RW forwarding muxes as above.
- Undefined: ma_* and rw_* inputs are ignored, and ex_a/ex_b come straight from of_op1/of_op2/immediate. The hazard unit must stall instead.

Test Plan:
- Reset: hold rst 2 cycles with of_valid=1 → ex_valid=0, all sh_is_*=0, ex_a=0, of_ready=1.
- lsl r1,r2,#4 (opcode 01010, I=1, imm=0x00004), of_op1=0x000000F0, ex_ready=1 → next cycle ex_valid=1, sh_is_lsl=1, sh_m=0x000000F0, sh_n=4.
- Immediate modifiers with I=1, imm[15:0]=0xF000 → ex_b=0xFFFFF000 (00), 0x0000F000 (u), 0xF0000000 (h).
- Forwarding (OF_EX_FWD_EN): asr with rs1=3, of_op1=0, ma_wr_en=1/ma_rd=3/ma_val=0xFF000000, rw_wr_en=1/rw_rd=3/rw_val=0x1 → sh_m=0xFF000000, sh_is_asr=1. Without the macro → sh_m=0.
- Stall: ex_ready=0 for 3 cycles after a latched lsr → outputs unchanged and of_ready=0 throughout. Raising ex_ready with a new of_valid → new instruction appears next cycle.
- Flush: flush=1 together with of_valid=1 while holding a valid lsl → next cycle ex_valid=0, sh_is_lsl=0, and the incoming instruction is not latched.

Source files
------------

// File: rtl/of_ex_latch.sv
`default_nettype none
// ============================================================================
// Module   : of_ex_latch
// Brief    : OF->EX pipeline register for SimpleRisc. Builds operand B,
//            resolves MA/RW forwarding (macro OF_EX_FWD_EN) and drives the
//            shifter controls.
// Revision : 1.0 - initial release
// ============================================================================
module of_ex_latch #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              of_valid,
  output logic              of_ready,
  input  logic [31:0]       of_inst,
  input  logic [XLEN-1:0]   of_pc,
  input  logic [XLEN-1:0]   of_op1,
  input  logic [XLEN-1:0]   of_op2,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              ma_wr_en,
  input  logic [RIDX_W-1:0] ma_rd,
  input  logic [XLEN-1:0]   ma_val,
  input  logic              rw_wr_en,
  input  logic [RIDX_W-1:0] rw_rd,
  input  logic [XLEN-1:0]   rw_val,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_opcode,
  output logic [RIDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   sh_m,
  output logic [4:0]        sh_n,
  output logic              sh_is_lsl,
  output logic              sh_is_lsr,
  output logic              sh_is_asr
);

  localparam logic [4:0] c_op_lsl = 5'b01010;
  localparam logic [4:0] c_op_lsr = 5'b01011;
  localparam logic [4:0] c_op_asr = 5'b01100;

  logic [4:0]        w_opcode;
  logic              w_imm_flag;
  logic [RIDX_W-1:0] w_rd;
  logic [RIDX_W-1:0] w_rs1;
  logic [RIDX_W-1:0] w_rs2;
  logic [17:0]       w_imm;
  logic [XLEN-1:0]   w_imm_b;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_op2_fwd;
  logic [XLEN-1:0]   w_b;
  logic              w_xfer;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [4:0]        r_opcode;
  logic [RIDX_W-1:0] r_rd;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_lsl;
  logic              r_lsr;
  logic              r_asr;

  assign w_opcode   = of_inst[31:27];
  assign w_imm_flag = of_inst[26];
  assign w_rd       = RIDX_W'(of_inst[25:22]);
  assign w_rs1      = RIDX_W'(of_inst[21:18]);
  assign w_rs2      = RIDX_W'(of_inst[17:14]);
  assign w_imm      = of_inst[17:0];

  // Modifier 11 is reserved and decodes like the default sign-extended form
  always_comb begin
    w_imm_b = {{(XLEN-16){w_imm[15]}}, w_imm[15:0]};
    case (w_imm[17:16])
      2'b01:   w_imm_b = XLEN'(w_imm[15:0]);
      2'b10:   w_imm_b = XLEN'({w_imm[15:0], 16'h0000});
      default: w_imm_b = {{(XLEN-16){w_imm[15]}}, w_imm[15:0]};
    endcase
  end

`ifdef OF_EX_FWD_EN
  // MA is the younger producer, so it takes precedence over RW
  always_comb begin
    w_a = of_op1;
    if (ma_wr_en && (ma_rd == w_rs1))      w_a = ma_val;
    else if (rw_wr_en && (rw_rd == w_rs1)) w_a = rw_val;

    w_op2_fwd = of_op2;
    if (ma_wr_en && (ma_rd == w_rs2))      w_op2_fwd = ma_val;
    else if (rw_wr_en && (rw_rd == w_rs2)) w_op2_fwd = rw_val;
  end
`else
  logic w_unused_fwd;
  assign w_a          = of_op1;
  assign w_op2_fwd    = of_op2;
  assign w_unused_fwd = ^{ma_wr_en, ma_rd, ma_val, rw_wr_en, rw_rd, rw_val, w_rs1, w_rs2};
`endif

  assign w_b      = w_imm_flag ? w_imm_b : w_op2_fwd;
  assign of_ready = !r_valid || ex_ready;
  assign w_xfer   = of_valid && of_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_lsl    <= 1'b0;
      r_lsr    <= 1'b0;
      r_asr    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_lsl   <= 1'b0;
      r_lsr   <= 1'b0;
      r_asr   <= 1'b0;
    end else if (w_xfer) begin
      r_valid  <= 1'b1;
      r_pc     <= of_pc;
      r_opcode <= w_opcode;
      r_rd     <= w_rd;
      r_a      <= w_a;
      r_b      <= w_b;
      r_lsl    <= (w_opcode == c_op_lsl);
      r_lsr    <= (w_opcode == c_op_lsr);
      r_asr    <= (w_opcode == c_op_asr);
    end else if (ex_ready) begin
      // Consumed with nothing behind it; data may go stale but selects must drop
      r_valid <= 1'b0;
      r_lsl   <= 1'b0;
      r_lsr   <= 1'b0;
      r_asr   <= 1'b0;
    end
  end

  assign ex_valid  = r_valid;
  assign ex_pc     = r_pc;
  assign ex_opcode = r_opcode;
  assign ex_rd     = r_rd;
  assign ex_a      = r_a;
  assign ex_b      = r_b;
  assign sh_m      = r_a;
  assign sh_n      = r_b[4:0];
  assign sh_is_lsl = r_lsl;
  assign sh_is_lsr = r_lsr;
  assign sh_is_asr = r_asr;

endmodule
`default_nettype wire

// File: tb/tb_of_ex_latch.sv
`default_nettype none
// Testbench for of_ex_latch: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_of_ex_latch;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 4;
`ifdef OF_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              of_valid = 1'b0;
  logic              of_ready;
  logic [31:0]       of_inst = '0;
  logic [XLEN-1:0]   of_pc = '0, of_op1 = '0, of_op2 = '0;
  logic              flush = 1'b0, ex_ready = 1'b1;
  logic              ma_wr_en = 1'b0, rw_wr_en = 1'b0;
  logic [RIDX_W-1:0] ma_rd = '0, rw_rd = '0;
  logic [XLEN-1:0]   ma_val = '0, rw_val = '0;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_a, ex_b, sh_m;
  logic [4:0]        ex_opcode, sh_n;
  logic [RIDX_W-1:0] ex_rd;
  logic              sh_is_lsl, sh_is_lsr, sh_is_asr;

  of_ex_latch #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_ready(of_ready),
    .of_inst(of_inst), .of_pc(of_pc), .of_op1(of_op1), .of_op2(of_op2),
    .flush(flush), .ex_ready(ex_ready),
    .ma_wr_en(ma_wr_en), .ma_rd(ma_rd), .ma_val(ma_val),
    .rw_wr_en(rw_wr_en), .rw_rd(rw_rd), .rw_val(rw_val),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .sh_m(sh_m), .sh_n(sh_n),
    .sh_is_lsl(sh_is_lsl), .sh_is_lsr(sh_is_lsr), .sh_is_asr(sh_is_asr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: what EX holds, as a transaction
  bit          m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_a = '0, m_b = '0;
  logic [4:0]  m_op = '0;
  logic [3:0]  m_rd = '0;

  function automatic logic [31:0] src_val(input logic [3:0] s, input logic [31:0] rf);
    if (FWD && ma_wr_en && ma_rd == s) return ma_val;
    if (FWD && rw_wr_en && rw_rd == s) return rw_val;
    return rf;
  endfunction

  function automatic logic [31:0] imm_val(input logic [17:0] imm);
    int unsigned v;
    v = imm[15:0];
    case (imm[17:16])
      2'd1:    return v;
      2'd2:    return v * 65536;
      default: return (v >= 32768) ? v - 65536 : v;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = 0; m_pc = '0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
    end else if (flush) begin
      m_valid = 0;
    end else if (of_valid && (!m_valid || ex_ready)) begin
      m_valid = 1;
      m_pc    = of_pc;
      m_op    = of_inst[31:27];
      m_rd    = of_inst[25:22];
      m_a     = src_val(of_inst[21:18], of_op1);
      m_b     = of_inst[26] ? imm_val(of_inst[17:0]) : src_val(of_inst[17:14], of_op2);
    end else if (ex_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, " of_ready"}, {31'b0, of_ready}, {31'b0, !m_valid || ex_ready});
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, " ex_valid"}, {31'b0, ex_valid}, {31'b0, m_valid});
    chk({tag, " sh_is_lsl"}, {31'b0, sh_is_lsl}, {31'b0, m_valid && m_op == 5'd10});
    chk({tag, " sh_is_lsr"}, {31'b0, sh_is_lsr}, {31'b0, m_valid && m_op == 5'd11});
    chk({tag, " sh_is_asr"}, {31'b0, sh_is_asr}, {31'b0, m_valid && m_op == 5'd12});
    if (m_valid) begin
      chk({tag, " ex_pc"}, ex_pc, m_pc);
      chk({tag, " ex_opcode"}, {27'b0, ex_opcode}, {27'b0, m_op});
      chk({tag, " ex_rd"}, {28'b0, ex_rd}, {28'b0, m_rd});
      chk({tag, " ex_a"}, ex_a, m_a);
      chk({tag, " ex_b"}, ex_b, m_b);
      chk({tag, " sh_m"}, sh_m, m_a);
      chk({tag, " sh_n"}, {27'b0, sh_n}, {27'b0, m_b[4:0]});
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic i, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [17:0] low);
    return {op, i, rd, rs1, low};
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic        i;
    logic [17:0] low;
    logic [31:0] op1, op2, exp_a, exp_b;
    logic        lsl, lsr, asr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{5'b01010, 1'b1, 18'h00004, 32'h000000F0, 32'h0, 32'h000000F0, 32'h00000004, 1, 0, 0};
    tbl[1] = '{5'b00000, 1'b1, 18'h0F000, 32'h11111111, 32'h0, 32'h11111111, 32'hFFFFF000, 0, 0, 0};
    tbl[2] = '{5'b00000, 1'b1, 18'h1F000, 32'h22222222, 32'h0, 32'h22222222, 32'h0000F000, 0, 0, 0};
    tbl[3] = '{5'b00000, 1'b1, 18'h2F000, 32'h33333333, 32'h0, 32'h33333333, 32'hF0000000, 0, 0, 0};
    tbl[4] = '{5'b00000, 1'b1, 18'h3F000, 32'h44444444, 32'h0, 32'h44444444, 32'hFFFFF000, 0, 0, 0};
    tbl[5] = '{5'b01011, 1'b0, 18'h08000, 32'h0000ABCD, 32'h12345678, 32'h0000ABCD, 32'h12345678, 0, 1, 0};
    tbl[6] = '{5'b01100, 1'b1, 18'h0001F, 32'h80000000, 32'h0, 32'h80000000, 32'h0000001F, 0, 0, 1};
    tbl[7] = '{5'b01101, 1'b1, 18'h07FFF, 32'h00000005, 32'h0, 32'h00000005, 32'h00007FFF, 0, 0, 0};

    // Reset held two cycles with an instruction offered
    rst = 1; of_valid = 1; of_inst = mk(5'b01010, 1, 4'd1, 4'd2, 18'h4); of_op1 = 32'hDEAD;
    step("rst0");
    step("rst1");
    chk("rst ex_a", ex_a, 32'h0);
    chk("rst of_ready", {31'b0, of_ready}, 32'h1);
    rst = 0; of_valid = 0;

    // Vector table, one transfer per entry with EX always ready
    foreach (tbl[k]) begin
      of_valid = 1; ex_ready = 1; flush = 0; ma_wr_en = 0; rw_wr_en = 0;
      of_inst = mk(tbl[k].op, tbl[k].i, 4'(k), 4'd2, tbl[k].low);
      of_pc = 32'h1000 + 32'(k) * 4; of_op1 = tbl[k].op1; of_op2 = tbl[k].op2;
      step($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d ex_a", k), ex_a, tbl[k].exp_a);
      chk($sformatf("tbl%0d ex_b", k), ex_b, tbl[k].exp_b);
      chk($sformatf("tbl%0d sh_n", k), {27'b0, sh_n}, {27'b0, tbl[k].exp_b[4:0]});
      chk($sformatf("tbl%0d shsel", k), {29'b0, sh_is_lsl, sh_is_lsr, sh_is_asr},
          {29'b0, tbl[k].lsl, tbl[k].lsr, tbl[k].asr});
    end
    of_valid = 0;
    step("drain");

    // Forwarding: MA and RW both target rs1, MA must win
    of_valid = 1; of_inst = mk(5'b01100, 1, 4'd5, 4'd3, 18'h1); of_op1 = 0; of_pc = 32'h2000;
    ma_wr_en = 1; ma_rd = 3; ma_val = 32'hFF000000;
    rw_wr_en = 1; rw_rd = 3; rw_val = 32'h1;
    step("fwd");
    chk("fwd sh_m", sh_m, FWD ? 32'hFF000000 : 32'h0);
    chk("fwd sh_is_asr", {31'b0, sh_is_asr}, 32'h1);
    ma_wr_en = 0; rw_wr_en = 0;

    // Stall: hold a latched lsr for three cycles while OF keeps offering
    of_inst = mk(5'b01011, 1, 4'd6, 4'd1, 18'h3); of_op1 = 32'hCAFE0000; of_pc = 32'h3000;
    step("stall ld");
    ex_ready = 0; of_inst = mk(5'b01010, 1, 4'd7, 4'd1, 18'h9); of_op1 = 32'h5; of_pc = 32'h3004;
    for (int c = 0; c < 3; c++) begin
      step($sformatf("stall%0d", c));
      chk($sformatf("stall%0d ex_pc", c), ex_pc, 32'h3000);
      chk($sformatf("stall%0d of_ready", c), {31'b0, of_ready}, 32'h0);
    end
    ex_ready = 1;
    step("stall rel");
    chk("stall rel ex_pc", ex_pc, 32'h3004);

    // Flush while holding a valid lsl with a new instruction offered
    ex_ready = 0; of_valid = 0;
    step("flush hold");
    flush = 1; of_valid = 1; of_pc = 32'h4000;
    step("flush");
    chk("flush ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("flush sh_is_lsl", {31'b0, sh_is_lsl}, 32'h0);
    flush = 0; of_valid = 0; ex_ready = 1;
    step("post flush");

    // Reset asserted during a transfer discards it
    of_valid = 1; rst = 1;
    step("rst xfer");
    rst = 0; of_valid = 0;
    step("rst idle");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      of_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      of_inst  = {5'($urandom_range(8, 14)), 27'($urandom)};
      of_pc    = $urandom; of_op1 = $urandom; of_op2 = $urandom;
      ma_wr_en = 1'($urandom); ma_rd = 4'($urandom); ma_val = $urandom;
      rw_wr_en = 1'($urandom); rw_rd = 4'($urandom); rw_val = $urandom;
      step($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
